// File: rtl/chain_control_ingr_pkg.sv
// Shared types and constants for the ingress forwarding-table update path.
package chain_control_ingr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned ERR_RANGE   = 0;
    localparam int unsigned ERR_TIMEOUT = 1;
    localparam int unsigned ERR_OVERRUN = 2;

    localparam int unsigned DEF_SESSION_W   = 10;
    localparam int unsigned DEF_CHANNEL_W   = 9;
    localparam int unsigned DEF_NUM_SESSION = 1024;

endpackage

// File: rtl/chain_control_ingr_fwd_update_pend.sv
// One-deep holding slot for requests that arrive while the sequencer is busy;
// a newer request overwrites an unconsumed one and flags the overrun.
module chain_control_ingr_fwd_update_pend
    import chain_control_ingr_pkg::*;
(
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        i_load,
    input  logic        i_consume,
    input  logic [31:0] i_req,
    input  logic [31:0] i_session,
    input  logic [31:0] i_channel,
    output logic        o_full,
    output logic        o_overrun,
    output logic [31:0] o_req,
    output logic [31:0] o_session,
    output logic [31:0] o_channel
);

    logic        r_full;
    logic [31:0] r_req;
    logic [31:0] r_session;
    logic [31:0] r_channel;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_full    <= 1'b0;
            r_req     <= '0;
            r_session <= '0;
            r_channel <= '0;
        end else if (i_load) begin
            r_full    <= 1'b1;
            r_req     <= i_req;
            r_session <= i_session;
            r_channel <= i_channel;
        end else if (i_consume) begin
            r_full    <= 1'b0;
        end
    end

    // Refilling in the same cycle the slot is drained is not an overrun.
    assign o_overrun = i_load && r_full && !i_consume;
    assign o_full    = r_full;
    assign o_req     = r_req;
    assign o_session = r_session;
    assign o_channel = r_channel;

endmodule

// File: rtl/chain_control_ingr_fwd_update_ctrl.sv
// Detects software forwarding-table update requests, range-checks them and
// issues one valid/ready table write each, reporting completion and errors.
module chain_control_ingr_fwd_update_ctrl
    import chain_control_ingr_pkg::*;
#(
    parameter int unsigned SESSION_W   = DEF_SESSION_W,
    parameter int unsigned CHANNEL_W   = DEF_CHANNEL_W,
    parameter int unsigned NUM_SESSION = DEF_NUM_SESSION,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 ap_start,
    input  logic [31:0]          ingr_forward_update_req,
    input  logic [31:0]          ingr_forward_session,
    input  logic [31:0]          ingr_forward_channel,
    output logic                 tbl_wr_valid,
    input  logic                 tbl_wr_ready,
    output logic [SESSION_W-1:0] tbl_wr_session,
    output logic [CHANNEL_W-1:0] tbl_wr_channel,
    output logic [31:0]          ingr_forward_update_resp,
    output logic                 ingr_forward_update_busy,
    output logic [7:0]           ingr_forward_update_err,
    output logic [15:0]          ingr_forward_update_drop_cnt
);

    localparam int unsigned TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [32:0] SESS_LIM = 33'(NUM_SESSION);
    localparam logic [32:0] CH_LIM   = 33'(1) << CHANNEL_W;

    state_t r_state;
    state_t w_next;

    logic [31:0]          r_shadow;
    logic [31:0]          r_wreq;
    logic [31:0]          r_wsess;
    logic [31:0]          r_wch;
    logic [TMO_W-1:0]     r_tmo;
    logic [SESSION_W-1:0] r_tbl_sess;
    logic [CHANNEL_W-1:0] r_tbl_ch;
    logic [31:0]          r_resp;
    logic [2:0]           r_err;
    logic [15:0]          r_drop;

    logic        w_detect;
    logic        w_take;
    logic        w_consume;
    logic        w_load;
    logic        w_range_bad;
    logic        w_rej;
    logic        w_tmo;
    logic        w_pend_full;
    logic        w_overrun;
    logic [31:0] w_pend_req;
    logic [31:0] w_pend_sess;
    logic [31:0] w_pend_ch;
    logic [1:0]  w_inc;
    logic [16:0] w_drop_sum;

    // Shadow follows the input every cycle: equal to "update on detect" while
    // started, and gives the required tracking while ap_start is low.
    assign w_detect    = ap_start && (ingr_forward_update_req != r_shadow);
    assign w_consume   = (r_state == IDLE) && w_pend_full;
    assign w_take      = (r_state == IDLE) && (w_pend_full || w_detect);
    assign w_load      = w_detect && !((r_state == IDLE) && !w_pend_full);
    assign w_range_bad = ({1'b0, r_wsess} >= SESS_LIM) || ({1'b0, r_wch} >= CH_LIM);

    chain_control_ingr_fwd_update_pend u_pend (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .i_load    (w_load),
        .i_consume (w_consume),
        .i_req     (ingr_forward_update_req),
        .i_session (ingr_forward_session),
        .i_channel (ingr_forward_channel),
        .o_full    (w_pend_full),
        .o_overrun (w_overrun),
        .o_req     (w_pend_req),
        .o_session (w_pend_sess),
        .o_channel (w_pend_ch)
    );

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_rej  = 1'b0;
        w_tmo  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                if (w_range_bad) begin
                    w_rej  = 1'b1;
                    w_next = DONE;
                end else begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                if (tbl_wr_ready) begin
                    w_next = DONE;
                end else if (r_tmo == TMO_LAST) begin
                    w_tmo  = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Range reject/timeout and an overrun can land in the same cycle.
    assign w_inc      = {1'b0, w_rej | w_tmo} + {1'b0, w_overrun};
    assign w_drop_sum = {1'b0, r_drop} + 17'(w_inc);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_shadow   <= '0;
            r_wreq     <= '0;
            r_wsess    <= '0;
            r_wch      <= '0;
            r_tmo      <= '0;
            r_tbl_sess <= '0;
            r_tbl_ch   <= '0;
            r_resp     <= '0;
            r_err      <= '0;
            r_drop     <= '0;
        end else begin
            r_shadow <= ingr_forward_update_req;
            if (w_take) begin
                if (w_pend_full) begin
                    r_wreq  <= w_pend_req;
                    r_wsess <= w_pend_sess;
                    r_wch   <= w_pend_ch;
                end else begin
                    r_wreq  <= ingr_forward_update_req;
                    r_wsess <= ingr_forward_session;
                    r_wch   <= ingr_forward_channel;
                end
            end
            if ((r_state == CHECK) && !w_range_bad) begin
                r_tbl_sess <= r_wsess[SESSION_W-1:0];
                r_tbl_ch   <= r_wch[CHANNEL_W-1:0];
                r_tmo      <= '0;
            end else if (r_state == WRITE) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (r_state == DONE) begin
                r_resp <= r_wreq;
            end
            r_err[ERR_RANGE]   <= r_err[ERR_RANGE]   | w_rej;
            r_err[ERR_TIMEOUT] <= r_err[ERR_TIMEOUT] | w_tmo;
            r_err[ERR_OVERRUN] <= r_err[ERR_OVERRUN] | w_overrun;
            r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign tbl_wr_valid                 = (r_state == WRITE);
    assign tbl_wr_session               = r_tbl_sess;
    assign tbl_wr_channel               = r_tbl_ch;
    assign ingr_forward_update_resp     = r_resp;
    assign ingr_forward_update_busy     = (r_state != IDLE) || w_pend_full;
    assign ingr_forward_update_err      = {5'b0, r_err};
    assign ingr_forward_update_drop_cnt = r_drop;

endmodule
